// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV64 control unit: opcodes, FSM states,
// ALU operation codes, halt reasons and the decoded instruction class.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LD   = 3'd1,
    C_SD   = 3'd2,
    C_BEQ  = 3'd3,
    C_ADDI = 3'd4
  } iclass_t;

  typedef struct packed {
    logic is_r;
    logic is_ld;
    logic is_sd;
    logic is_beq;
    logic is_addi;
    logic illegal;
    logic is_zero;
  } dec_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing bus of the control unit: instruction/status inputs and the
// per-phase strobes, counters and halt status.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr;
  logic             alu_zero;
  logic             dmem_ready;
  logic [2:0]       state;
  logic             ir_write;
  logic             rf_latch;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             halted;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  instr, alu_zero, dmem_ready,
    output state, ir_write, rf_latch, pc_write, pc_src, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, halted, err_code,
           cycle_count, retired_count
  );

  modport slave (
    output instr, alu_zero, dmem_ready,
    input  state, ir_write, rf_latch, pc_write, pc_src, alu_src, alu_op,
           mem_read, mem_write, mem_to_reg, reg_write, halted, err_code,
           cycle_count, retired_count
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Combinational opcode classifier; an all-zero word is reported as is_zero only.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;

  always_comb begin
    op  = opcode_of(instr);
    dec = '0;
    if (instr == '0) begin
      dec.is_zero = 1'b1;
    end else begin
      case (op)
        OP_R:    dec.is_r    = 1'b1;
        OP_LD:   dec.is_ld   = 1'b1;
        OP_SD:   dec.is_sd   = 1'b1;
        OP_BEQ:  dec.is_beq  = 1'b1;
        OP_ADDI: dec.is_addi = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the sequential RV64 datapath, with memory-wait
// timeout, sticky halt and saturating cycle/retire counters.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  iclass_t           cls_q, cls_d;
  err_t              err_q, err_d;
  logic              rd_zero_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cyc_q, ret_q;
  dec_t              dec;

  logic    ir_write, rf_latch, pc_write, pc_src, alu_src;
  logic    mem_read, mem_write, mem_to_reg, reg_write;
  alu_op_t alu_op;

  ctrl_decode u_dec (
    .instr (bus.instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      err_q     <= ERR_NONE;
      rd_zero_q <= 1'b0;
      wait_q    <= '0;
      cyc_q     <= '0;
      ret_q     <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      if (state_q == S_DECODE)
        rd_zero_q <= (bus.instr[11:7] == 5'd0);
      // EXECUTE always precedes MEM, so clearing here clears on MEM entry
      if (state_q == S_EXECUTE)
        wait_q <= '0;
      else if (state_q == S_MEM && !bus.dmem_ready)
        wait_q <= wait_q + WAIT_W'(1);
      if (state_q != S_HALT && cyc_q != '1)
        cyc_q <= cyc_q + CNT_W'(1);
      if (pc_write && ret_q != '1)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    err_d      = err_q;
    ir_write   = 1'b0;
    rf_latch   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        rf_latch = 1'b1;
        if (dec.is_zero) begin
          state_d = S_HALT;
          err_d   = ERR_NONE;
        end else if (dec.illegal) begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
          if (dec.is_r)        cls_d = C_R;
          else if (dec.is_ld)  cls_d = C_LD;
          else if (dec.is_sd)  cls_d = C_SD;
          else if (dec.is_beq) cls_d = C_BEQ;
          else if (dec.is_addi) cls_d = C_ADDI;
        end
      end

      S_EXECUTE: begin
        case (cls_q)
          C_R: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          C_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LD, C_SD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_op   = ALU_SUB;
            pc_write = 1'b1;
            pc_src   = bus.alu_zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_read  = (cls_q == C_LD);
        mem_write = (cls_q == C_SD);
        if (bus.dmem_ready) begin
          if (cls_q == C_LD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end

      S_WB: begin
        reg_write  = !rd_zero_q;
        mem_to_reg = (cls_q == C_LD);
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  assign bus.state         = state_q;
  assign bus.ir_write      = ir_write;
  assign bus.rf_latch      = rf_latch;
  assign bus.pc_write      = pc_write;
  assign bus.pc_src        = pc_src;
  assign bus.alu_src       = alu_src;
  assign bus.alu_op        = alu_op;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.err_code      = err_q;
  assign bus.cycle_count   = cyc_q;
  assign bus.retired_count = ret_q;

endmodule
